// File: rtl/cpu_exec_datapath_pkg.sv
// cpu_exec_datapath_pkg: ALU opcodes, CSR addresses and load types shared by the execute datapath.
package cpu_exec_datapath_pkg;
  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b1000;
  localparam logic [3:0] ALU_SLL     = 4'b0001;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SRA     = 4'b1101;
  localparam logic [3:0] ALU_SLT     = 4'b0010;
  localparam logic [3:0] ALU_SLTU    = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_OR      = 4'b0110;
  localparam logic [3:0] ALU_AND     = 4'b0111;
  localparam logic [3:0] ALU_PASS_A  = 4'b1001;
  localparam logic [3:0] ALU_PASS_B  = 4'b1010;
  localparam logic [3:0] ALU_AND_NOT = 4'b1011;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
endpackage

// File: rtl/cpu_exec_datapath_if.sv
// cpu_exec_datapath_if: control-decoder side (master) and datapath side (slave) of the execute block.
interface cpu_exec_datapath_if;
  logic [31:0] alu_src_a;
  logic [31:0] alu_src_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_borrow;
  logic        alu_lt;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wenable;
  logic [31:0] ld_data;
  logic [2:0]  ld_control;
  logic [31:0] ld_data_ext;
  modport master(output alu_src_a, alu_src_b, alu_control, csr_raddr, csr_waddr, csr_wdata,
                 csr_wenable, ld_data, ld_control,
                 input alu_result, alu_zero, alu_borrow, alu_lt, csr_rdata, ld_data_ext);
  modport slave(input alu_src_a, alu_src_b, alu_control, csr_raddr, csr_waddr, csr_wdata,
                csr_wenable, ld_data, ld_control,
                output alu_result, alu_zero, alu_borrow, alu_lt, csr_rdata, ld_data_ext);
endinterface

// File: rtl/cpu_exec_datapath_csr_file.sv
// cpu_exec_datapath_csr_file: machine-mode CSRs; CSR_COUNTERS_EN adds the 64-bit mcycle counter.
module cpu_exec_datapath_csr_file import cpu_exec_datapath_pkg::*; #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_raddr,
  output logic [31:0] o_rdata,
  input  logic [11:0] i_waddr,
  input  logic [31:0] i_wdata,
  input  logic        i_we
);
  logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mip;
`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] w_inc;
  assign w_inc = r_mcycle + 64'd1;
  // a write to one half overrides only that half's increment
  always_ff @(posedge clk or posedge rst)
    if (rst) r_mcycle <= '0;
    else begin
      r_mcycle[31:0]  <= (i_we && i_waddr == CSR_MCYCLE)  ? i_wdata : w_inc[31:0];
      r_mcycle[63:32] <= (i_we && i_waddr == CSR_MCYCLEH) ? i_wdata : w_inc[63:32];
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mstatus  <= '0;
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mip      <= '0;
    end else if (i_we) begin
      case (i_waddr)
        CSR_MSTATUS:  r_mstatus  <= i_wdata;
        CSR_MIE:      r_mie      <= i_wdata;
        CSR_MTVEC:    r_mtvec    <= {i_wdata[31:2], 2'b00};
        CSR_MSCRATCH: r_mscratch <= i_wdata;
        CSR_MEPC:     r_mepc     <= {i_wdata[31:2], 2'b00};
        CSR_MCAUSE:   r_mcause   <= i_wdata;
        CSR_MTVAL:    r_mtval    <= i_wdata;
        CSR_MIP:      r_mip      <= i_wdata;
        default: ;
      endcase
    end
  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      CSR_MSTATUS:  o_rdata = r_mstatus;
      CSR_MISA:     o_rdata = MISA_VALUE;
      CSR_MIE:      o_rdata = r_mie;
      CSR_MTVEC:    o_rdata = r_mtvec;
      CSR_MSCRATCH: o_rdata = r_mscratch;
      CSR_MEPC:     o_rdata = r_mepc;
      CSR_MCAUSE:   o_rdata = r_mcause;
      CSR_MTVAL:    o_rdata = r_mtval;
      CSR_MIP:      o_rdata = r_mip;
      CSR_MHARTID:  o_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_CYCLE:   o_rdata = r_mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH: o_rdata = r_mcycle[63:32];
`endif
      default: o_rdata = '0;
    endcase
  end
endmodule

// File: rtl/cpu_exec_datapath.sv
// cpu_exec_datapath: integer ALU with compare flags, CSR file and load extender.
// Optional macro CSR_COUNTERS_EN enables mcycle/mcycleh and the cycle/cycleh aliases.
module cpu_exec_datapath import cpu_exec_datapath_pkg::*; #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h4000_0120
) (
  input logic                  clk,
  input logic                  rst,
  cpu_exec_datapath_if.slave   io_dp
);
  logic [32:0] w_diff;
  logic [31:0] w_a, w_b;
  assign w_a = io_dp.alu_src_a;
  assign w_b = io_dp.alu_src_b;
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign io_dp.alu_borrow = w_diff[32];
  assign io_dp.alu_lt = $signed(w_a) < $signed(w_b);
  assign io_dp.alu_zero = io_dp.alu_result == '0;
  always_comb begin
    io_dp.alu_result = '0;
    case (io_dp.alu_control)
      ALU_ADD:     io_dp.alu_result = w_a + w_b;
      ALU_SUB:     io_dp.alu_result = w_diff[31:0];
      ALU_SLL:     io_dp.alu_result = w_a << w_b[4:0];
      ALU_SRL:     io_dp.alu_result = w_a >> w_b[4:0];
      ALU_SRA:     io_dp.alu_result = $unsigned($signed(w_a) >>> w_b[4:0]);
      ALU_SLT:     io_dp.alu_result = {31'd0, io_dp.alu_lt};
      ALU_SLTU:    io_dp.alu_result = {31'd0, io_dp.alu_borrow};
      ALU_XOR:     io_dp.alu_result = w_a ^ w_b;
      ALU_OR:      io_dp.alu_result = w_a | w_b;
      ALU_AND:     io_dp.alu_result = w_a & w_b;
      ALU_PASS_A:  io_dp.alu_result = w_a;
      ALU_PASS_B:  io_dp.alu_result = w_b;
      ALU_AND_NOT: io_dp.alu_result = w_a & ~w_b;
      default:     io_dp.alu_result = '0;
    endcase
  end
  always_comb begin
    io_dp.ld_data_ext = io_dp.ld_data;
    case (io_dp.ld_control)
      LD_B:    io_dp.ld_data_ext = {{24{io_dp.ld_data[7]}}, io_dp.ld_data[7:0]};
      LD_H:    io_dp.ld_data_ext = {{16{io_dp.ld_data[15]}}, io_dp.ld_data[15:0]};
      LD_BU:   io_dp.ld_data_ext = {24'd0, io_dp.ld_data[7:0]};
      LD_HU:   io_dp.ld_data_ext = {16'd0, io_dp.ld_data[15:0]};
      default: io_dp.ld_data_ext = io_dp.ld_data;
    endcase
  end
  cpu_exec_datapath_csr_file #(.HART_ID(HART_ID), .MISA_VALUE(MISA_VALUE)) u_csr (
    .clk     (clk),
    .rst     (rst),
    .i_raddr (io_dp.csr_raddr),
    .o_rdata (io_dp.csr_rdata),
    .i_waddr (io_dp.csr_waddr),
    .i_wdata (io_dp.csr_wdata),
    .i_we    (io_dp.csr_wenable)
  );
endmodule

// File: tb/tb_cpu_exec_datapath.sv
// tb_cpu_exec_datapath: directed scoreboard bench for the execute datapath.
module tb_cpu_exec_datapath;
  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  cpu_exec_datapath_if dp_if ();
  cpu_exec_datapath dut (.clk(clk), .rst(rst), .io_dp(dp_if));
  always #5 clk = ~clk;
  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty obs=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        failures++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    dp_if.alu_control = op;
    dp_if.alu_src_a = a;
    dp_if.alu_src_b = b;
    #1;
  endtask
  task automatic csr_rd(input logic [11:0] addr);
    dp_if.csr_raddr = addr;
    #1;
  endtask
  task automatic csr_wr(input logic [11:0] addr, input logic [31:0] d);
    @(negedge clk);
    dp_if.csr_waddr = addr;
    dp_if.csr_wdata = d;
    dp_if.csr_wenable = 1'b1;
    @(posedge clk);
    #1;
    dp_if.csr_wenable = 1'b0;
  endtask
  task automatic ld(input logic [2:0] c);
    dp_if.ld_control = c;
    #1;
  endtask
  initial begin
    dp_if.alu_src_a = '0;
    dp_if.alu_src_b = '0;
    dp_if.alu_control = '0;
    dp_if.csr_raddr = '0;
    dp_if.csr_waddr = '0;
    dp_if.csr_wdata = '0;
    dp_if.csr_wenable = 1'b0;
    dp_if.ld_data = 32'h1234_8681;
    dp_if.ld_control = '0;
    #12;
    push("rst_mstatus", 32'h0); csr_rd(12'h300); chk(dp_if.csr_rdata);
    push("rst_mscratch", 32'h0); csr_rd(12'h340); chk(dp_if.csr_rdata);
    @(negedge clk);
    rst = 1'b0;
    push("add", 32'h8000_0000); push("add_zero", 32'h0);
    alu(4'b0000, 32'h7FFF_FFFF, 32'h1); chk(dp_if.alu_result); chk({31'd0, dp_if.alu_zero});
    push("sub", 32'h0); push("sub_zero", 32'h1); push("sub_borrow", 32'h0); push("sub_lt", 32'h0);
    alu(4'b1000, 32'd5, 32'd5);
    chk(dp_if.alu_result); chk({31'd0, dp_if.alu_zero}); chk({31'd0, dp_if.alu_borrow}); chk({31'd0, dp_if.alu_lt});
    push("cmp_borrow", 32'h0); push("cmp_lt", 32'h1);
    alu(4'b0000, 32'hFFFF_FFFF, 32'h1); chk({31'd0, dp_if.alu_borrow}); chk({31'd0, dp_if.alu_lt});
    push("slt", 32'h1); alu(4'b0010, 32'hFFFF_FFFF, 32'h1); chk(dp_if.alu_result);
    push("sltu", 32'h0); alu(4'b0011, 32'hFFFF_FFFF, 32'h1); chk(dp_if.alu_result);
    push("sltu_1", 32'h1); alu(4'b0011, 32'h1, 32'hFFFF_FFFF); chk(dp_if.alu_result);
    push("sra", 32'hC000_0000); alu(4'b1101, 32'h8000_0000, 32'h21); chk(dp_if.alu_result);
    push("srl", 32'h4000_0000); alu(4'b0101, 32'h8000_0000, 32'h21); chk(dp_if.alu_result);
    push("sll", 32'h0000_0F00); alu(4'b0001, 32'h0000_000F, 32'h28); chk(dp_if.alu_result);
    push("and_not", 32'hF0); alu(4'b1011, 32'hFF, 32'h0F); chk(dp_if.alu_result);
    push("pass_b", 32'h1234_5000); alu(4'b1010, 32'hAAAA_AAAA, 32'h1234_5000); chk(dp_if.alu_result);
    push("pass_a", 32'hAAAA_AAAA); alu(4'b1001, 32'hAAAA_AAAA, 32'h1234_5000); chk(dp_if.alu_result);
    push("xor", 32'hF0F0_0FF0); alu(4'b0100, 32'hFF00_FF00, 32'h0FF0_F0F0); chk(dp_if.alu_result);
    push("or", 32'hFFF0_FFF0); alu(4'b0110, 32'hFF00_FF00, 32'h0FF0_F0F0); chk(dp_if.alu_result);
    push("and", 32'h0F00_F000); alu(4'b0111, 32'hFF00_FF00, 32'h0FF0_F0F0); chk(dp_if.alu_result);
    push("op_1100", 32'h0); push("op_1100_zero", 32'h1);
    alu(4'b1100, 32'h5, 32'h3); chk(dp_if.alu_result); chk({31'd0, dp_if.alu_zero});
    push("op_1111", 32'h0); alu(4'b1111, 32'h5, 32'h3); chk(dp_if.alu_result);
    @(negedge clk);
    dp_if.csr_raddr = 12'h340;
    dp_if.csr_waddr = 12'h340;
    dp_if.csr_wdata = 32'hDEAD_BEEF;
    dp_if.csr_wenable = 1'b1;
    #1;
    push("mscratch_old", 32'h0); chk(dp_if.csr_rdata);
    @(posedge clk);
    #1;
    dp_if.csr_wenable = 1'b0;
    push("mscratch_new", 32'hDEAD_BEEF); chk(dp_if.csr_rdata);
    csr_wr(12'h301, 32'hFFFF_FFFF);
    push("misa_ro", 32'h4000_0120); csr_rd(12'h301); chk(dp_if.csr_rdata);
    push("mhartid", 32'h0); csr_rd(12'hF14); chk(dp_if.csr_rdata);
    csr_wr(12'h7C0, 32'h1111_1111);
    push("unimpl", 32'h0); csr_rd(12'h7C0); chk(dp_if.csr_rdata);
    csr_wr(12'h305, 32'h0000_1003);
    csr_wr(12'h341, 32'h0000_2227);
    push("mtvec_align", 32'h0000_1000); csr_rd(12'h305); chk(dp_if.csr_rdata);
    push("mepc_align", 32'h0000_2224); csr_rd(12'h341); chk(dp_if.csr_rdata);
    @(negedge clk);
    #1;
    rst = 1'b1;
    push("async_mtvec", 32'h0); csr_rd(12'h305); chk(dp_if.csr_rdata);
    push("async_mepc", 32'h0); csr_rd(12'h341); chk(dp_if.csr_rdata);
    push("ld_b", 32'hFFFF_FF81); ld(3'b000); chk(dp_if.ld_data_ext);
    push("ld_bu", 32'h0000_0081); ld(3'b100); chk(dp_if.ld_data_ext);
    push("ld_h", 32'hFFFF_8681); ld(3'b001); chk(dp_if.ld_data_ext);
    push("ld_hu", 32'h0000_8681); ld(3'b101); chk(dp_if.ld_data_ext);
    push("ld_w", 32'h1234_8681); ld(3'b010); chk(dp_if.ld_data_ext);
    push("ld_011", 32'h1234_8681); ld(3'b011); chk(dp_if.ld_data_ext);
    dp_if.ld_data = 32'h0000_7F7F;
    push("ld_b_pos", 32'h0000_007F); ld(3'b000); chk(dp_if.ld_data_ext);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef CSR_COUNTERS_EN
    push("mcycle_10", 32'd10); csr_rd(12'hB00); chk(dp_if.csr_rdata);
    push("cycle_alias", 32'd10); csr_rd(12'hC00); chk(dp_if.csr_rdata);
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    push("mcycle_pre", 32'hFFFF_FFFF); csr_rd(12'hB00); chk(dp_if.csr_rdata);
    push("mcycleh_pre", 32'h0); csr_rd(12'hB80); chk(dp_if.csr_rdata);
    @(posedge clk);
    #1;
    push("mcycleh_carry", 32'h1); csr_rd(12'hB80); chk(dp_if.csr_rdata);
    push("cycleh_alias", 32'h1); csr_rd(12'hC80); chk(dp_if.csr_rdata);
    push("mcycle_wrap", 32'h0); csr_rd(12'hB00); chk(dp_if.csr_rdata);
`else
    push("mcycle_absent", 32'h0); csr_rd(12'hB00); chk(dp_if.csr_rdata);
    csr_wr(12'hB80, 32'h5);
    push("mcycleh_absent", 32'h0); csr_rd(12'hB80); chk(dp_if.csr_rdata);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_exec_datapath.md
Name: cpu_exec_datapath

Overview:
Combinational/sequential support block for the single-cycle RV32I(+F moves) core. It bundles three units:
- the integer ALU, including the branch-compare flags;
- the machine-mode CSR register file, which supplies operands for the CSR instructions;
- the load-data sign/zero extender.

The core's control decoder drives all select/control inputs; results feed the writeback, PC and memory-address muxes.

Parameters:
HART_ID, 32'd0, value returned by read-only mhartid (0xF14)
MISA_VALUE, 32'h4000_0120, value returned by read-only misa (0x301): RV32, I and F

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
alu_src_a  in  32  ALU operand A
alu_src_b  in  32  ALU operand B
alu_control  in  4  ALU operation select
alu_result  out  32  ALU result
alu_zero  out  1  alu_result == 0
alu_borrow  out  1  unsigned A < B
alu_lt  out  1  signed A < B
csr_raddr  in  12  CSR read address
csr_rdata  out  32  CSR read data (combinational)
csr_waddr  in  12  CSR write address
csr_wdata  in  32  CSR write data
csr_wenable  in  1  CSR write strobe
ld_data  in  32  raw memory read word
ld_control  in  3  load funct3
ld_data_ext  out  32  extended load data

Behaviour:
- The ALU is purely combinational. Encodings of alu_control:
  - 0000 ADD; 1000 SUB
  - 0001 SLL; 0101 SRL; 1101 SRA (shift amount = B[4:0])
  - 0010 SLT (signed); 0011 SLTU (result is 0 or 1)
  - 0100 XOR; 0110 OR; 0111 AND
  - 1001 PASS_A; 1010 PASS_B; 1011 AND_NOT (A & ~B)
  - 1100, 1110, 1111 give result 0.
- All ALU arithmetic wraps modulo 2^32.
- ALU flags:
  - borrow and lt always come from the compare of A and B, independent of alu_control.
  - zero is derived from alu_result.
- CSR reads are combinational from current state. A read in the same cycle as a write to the same address returns the old value, which is what csrrw needs.
- CSR writes commit at the rising edge when csr_wenable=1.
- Implemented read/write CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
- Read-only CSRs: misa 0x301 and mhartid 0xF14. Writes to them are ignored.
- Unimplemented addresses read 0; writes to them are ignored.
- mtvec[1:0] and mepc[1:0] are forced to 0 on write.
- Reset (rst high, asynchronous): every writable CSR clears to 0. This includes counters. csr_rdata then reflects the zeros immediately.
- Load extender is combinational and uses the low bits of ld_data; the memory delivers the addressed data right-aligned. Encodings of ld_control:
  - 000 LB: sign-extend [7:0]
  - 001 LH: sign-extend [15:0]
  - 010 LW: pass through
  - 100 LBU: zero-extend [7:0]
  - 101 LHU: zero-extend [15:0]
  - 011, 110, 111: pass through unchanged.
- ALU and extender outputs carry no state and are unaffected by reset.

Optional Feature:
CSR_COUNTERS_EN
- Defined:
  - Adds mcycle 0xB00 and mcycleh 0xB80 (64-bit counter, +1 every clk when not in reset).
  - Adds read-only aliases cycle 0xC00 and cycleh 0xC80.
  - A CSR write to mcycle/mcycleh replaces that half in place of the increment for that cycle.
  - A carry out of mcycle[31:0] propagates to mcycleh.
- Undefined: these addresses behave as unimplemented (read 0, writes ignored).

Decomposition:
- Shared package/header cpu_alu.vh holds:
  - the ALU_* opcode constants above;
  - CSR address constants CSR_MSTATUS etc.;
  - load-type constants LD_B, LD_H, LD_W, LD_BU, LD_HU.
- One sub-module is natural: cpu_csr_file, holding all CSR state and the counter logic.
- ALU and extender stay inline as combinational always blocks.

Test Plan:
- ALU arithmetic:
  - A=0x7FFFFFFF, B=1, ADD -> 0x80000000, zero=0.
  - A=5, B=5, SUB -> 0, zero=1, borrow=0, lt=0.
  - A=0xFFFFFFFF, B=1 -> borrow=0, lt=1.
- ALU shifts and misc ops:
  - A=0x80000000, B=0x21, SRA -> 0xC0000000 (shamt 1); SRL -> 0x40000000.
  - AND_NOT A=0xFF, B=0x0F -> 0xF0.
  - PASS_B B=0x12345000 -> 0x12345000.
- CSR write/read: write mscratch=0xDEADBEEF with csr_raddr=0x340 -> old 0 during the write cycle, 0xDEADBEEF after the edge. Write misa -> still reads 0x40000120. Write 0x7C0 -> reads 0.
- CSR reset: after writes, assert rst mid-cycle asynchronously -> mtvec and mepc read 0 before the next clock edge.
- Load extend, ld_data=0x1234_8681:
  - LB -> 0xFFFFFF81; LBU -> 0x00000081
  - LH -> 0xFFFF8681; LHU -> 0x00008681
  - LW -> 0x12348681
- CSR_COUNTERS_EN: release reset, run 10 clocks -> mcycle reads 10. Preload mcycle=0xFFFFFFFF -> mcycleh increments to 1 on the next cycle.
